// File: rtl/lsq_pkg.sv
// rtl/lsq_pkg.sv - shared types and default widths for the load/store queue
package lsq_pkg;

  typedef enum logic {
    LSQ_LOAD  = 1'b0,
    LSQ_STORE = 1'b1
  } lsq_op_e;

  localparam int LSQ_LANES       = 8;
  localparam int LSQ_ADDR_WIDTH  = 8;
  localparam int LSQ_DATA_WIDTH  = 16;
  localparam int LSQ_DEPTH       = 32;
  localparam int LSQ_MEM_LATENCY = 5;
  localparam int LSQ_WARP_BITS   = 2;
  localparam int LSQ_REG_BITS    = 4;
  localparam int LSQ_TIMER_BITS  = 8;

  // Entry layout at the default widths, as seen by the controller.
  typedef struct packed {
    logic                                  valid;
    logic [LSQ_TIMER_BITS-1:0]             timer;
    lsq_op_e                               op;
    logic [LSQ_WARP_BITS-1:0]              warp;
    logic [LSQ_REG_BITS-1:0]               dest;
    logic [LSQ_LANES-1:0]                  mask;
    logic [LSQ_LANES*LSQ_ADDR_WIDTH-1:0]   addr;
    logic [LSQ_LANES*LSQ_DATA_WIDTH-1:0]   data;
  } lsq_entry_t;

endpackage

// File: rtl/lsq_param_if.sv
// rtl/lsq_param_if.sv - enqueue/dequeue/status bundle between controller and queue
interface lsq_param_if
  import lsq_pkg::*;
#(
  parameter int LANES      = LSQ_LANES,
  parameter int ADDR_WIDTH = LSQ_ADDR_WIDTH,
  parameter int DATA_WIDTH = LSQ_DATA_WIDTH,
  parameter int DEPTH      = LSQ_DEPTH,
  parameter int WARP_BITS  = LSQ_WARP_BITS,
  parameter int REG_BITS   = LSQ_REG_BITS
) ();

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                         enq_valid;
  logic                         enq_ready;
  logic                         enq_is_store;
  logic [WARP_BITS-1:0]         enq_warp;
  logic [REG_BITS-1:0]          enq_dest;
  logic [LANES-1:0]             enq_mask;
  logic [LANES*ADDR_WIDTH-1:0]  enq_addr;
  logic [LANES*DATA_WIDTH-1:0]  enq_data;

  logic                         deq_valid;
  logic                         deq_ready;
  logic                         deq_is_store;
  logic [WARP_BITS-1:0]         deq_warp;
  logic [REG_BITS-1:0]          deq_dest;
  logic [LANES-1:0]             deq_mask;
  logic [LANES*ADDR_WIDTH-1:0]  deq_addr;
  logic [LANES*DATA_WIDTH-1:0]  deq_data;

  logic [CNT_W-1:0]             count;
  logic                         full;
  logic                         empty;

  modport master (
    output enq_valid, enq_is_store, enq_warp, enq_dest, enq_mask, enq_addr, enq_data,
    output deq_ready,
    input  enq_ready,
    input  deq_valid, deq_is_store, deq_warp, deq_dest, deq_mask, deq_addr, deq_data,
    input  count, full, empty
  );

  modport slave (
    input  enq_valid, enq_is_store, enq_warp, enq_dest, enq_mask, enq_addr, enq_data,
    input  deq_ready,
    output enq_ready,
    output deq_valid, deq_is_store, deq_warp, deq_dest, deq_mask, deq_addr, deq_data,
    output count, full, empty
  );

endinterface

// File: rtl/lsq_entry_timer.sv
// rtl/lsq_entry_timer.sv - per-entry memory latency countdown
module lsq_entry_timer #(
  parameter int TIMER_BITS = 8,
  parameter int LATENCY    = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic done
);

  logic [TIMER_BITS-1:0] timer;

  // Counts down unconditionally while nonzero; the owner gates use by its valid bit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      timer <= '0;
    end else if (load) begin
      timer <= TIMER_BITS'(LATENCY);
    end else if (timer != '0) begin
      timer <= timer - TIMER_BITS'(1);
    end
  end

  assign done = (timer == '0);

endmodule

// File: rtl/lsq_param.sv
// rtl/lsq_param.sv - in-order load/store queue with modelled latency; optional LSQ_PERF_CNT_EN counters
module lsq_param
  import lsq_pkg::*;
#(
  parameter int LANES       = LSQ_LANES,
  parameter int ADDR_WIDTH  = LSQ_ADDR_WIDTH,
  parameter int DATA_WIDTH  = LSQ_DATA_WIDTH,
  parameter int DEPTH       = LSQ_DEPTH,
  parameter int MEM_LATENCY = LSQ_MEM_LATENCY,
  parameter int WARP_BITS   = LSQ_WARP_BITS,
  parameter int REG_BITS    = LSQ_REG_BITS
) (
  input  logic        clk,
  input  logic        reset,
  lsq_param_if.slave  bus
`ifdef LSQ_PERF_CNT_EN
  ,
  output logic [31:0] perf_loads,
  output logic [31:0] perf_stores,
  output logic [31:0] perf_stall
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    lsq_op_e                      op;
    logic [WARP_BITS-1:0]         warp;
    logic [REG_BITS-1:0]          dest;
    logic [LANES-1:0]             mask;
    logic [LANES*ADDR_WIDTH-1:0]  addr;
    logic [LANES*DATA_WIDTH-1:0]  data;
  } payload_t;

  payload_t          mem [DEPTH];
  payload_t          head;
  logic [DEPTH-1:0]  valid;
  logic [DEPTH-1:0]  done;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count_q;
  logic              full_q;
  logic              enq_fire;
  logic              deq_valid_q;
  logic              deq_fire;

  assign full_q      = (count_q == CNT_W'(DEPTH));
  assign enq_fire    = bus.enq_valid && !full_q;
  assign head        = mem[rd_ptr];
  assign deq_valid_q = valid[rd_ptr] && done[rd_ptr];
  assign deq_fire    = deq_valid_q && bus.deq_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_timer
    lsq_entry_timer #(
      .TIMER_BITS (LSQ_TIMER_BITS),
      .LATENCY    (MEM_LATENCY)
    ) u_timer (
      .clk   (clk),
      .reset (reset),
      .load  (enq_fire && (wr_ptr == PTR_W'(i))),
      .done  (done[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (enq_fire) begin
        valid[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + PTR_W'(1);
      end
      // Write and read slots never coincide: equal pointers mean empty or full.
      if (deq_fire) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + PTR_W'(1);
      end
      case ({enq_fire, deq_fire})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload needs no reset; the valid bits gate everything visible.
  always_ff @(posedge clk) begin
    if (reset && enq_fire) begin
      mem[wr_ptr] <= '{
        op:   lsq_op_e'(bus.enq_is_store),
        warp: bus.enq_warp,
        dest: bus.enq_dest,
        mask: bus.enq_mask,
        addr: bus.enq_addr,
        data: bus.enq_data
      };
    end
  end

  always_comb begin
    bus.deq_is_store = 1'b0;
    bus.deq_warp     = '0;
    bus.deq_dest     = '0;
    bus.deq_mask     = '0;
    bus.deq_addr     = '0;
    bus.deq_data     = '0;
    if (valid[rd_ptr]) begin
      bus.deq_is_store = (head.op == LSQ_STORE);
      bus.deq_warp     = head.warp;
      bus.deq_dest     = head.dest;
      bus.deq_mask     = head.mask;
      bus.deq_addr     = head.addr;
      bus.deq_data     = head.data;
    end
  end

  assign bus.deq_valid = deq_valid_q;
  assign bus.enq_ready = !full_q;
  assign bus.count     = count_q;
  assign bus.full      = full_q;
  assign bus.empty     = (count_q == '0);

`ifdef LSQ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_loads  <= '0;
      perf_stores <= '0;
      perf_stall  <= '0;
    end else begin
      if (deq_fire && head.op == LSQ_LOAD && perf_loads != '1) begin
        perf_loads <= perf_loads + 32'd1;
      end
      if (deq_fire && head.op == LSQ_STORE && perf_stores != '1) begin
        perf_stores <= perf_stores + 32'd1;
      end
      if (bus.enq_valid && full_q && perf_stall != '1) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_lsq_param.sv
// tb/tb_lsq_param.sv - scoreboard bench for lsq_param at default parameters
module tb_lsq_param;
  import lsq_pkg::*;

  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  lsq_param_if #(
    .LANES(8), .ADDR_WIDTH(8), .DATA_WIDTH(16), .DEPTH(DEPTH), .WARP_BITS(2), .REG_BITS(4)
  ) bus ();

`ifdef LSQ_PERF_CNT_EN
  logic [31:0] perf_loads, perf_stores, perf_stall;
`endif

  lsq_param #(
    .LANES(8), .ADDR_WIDTH(8), .DATA_WIDTH(16), .DEPTH(DEPTH), .MEM_LATENCY(5),
    .WARP_BITS(2), .REG_BITS(4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus)
`ifdef LSQ_PERF_CNT_EN
    ,
    .perf_loads  (perf_loads),
    .perf_stores (perf_stores),
    .perf_stall  (perf_stall)
`endif
  );

  typedef struct {
    logic         st;
    logic [1:0]   warp;
    logic [3:0]   dest;
    logic [7:0]   mask;
    logic [63:0]  addr;
    logic [127:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   n_deq = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mk_addr(input int s);
    logic [63:0] a;
    for (int j = 0; j < 8; j++) a[j*8 +: 8] = 8'(s + j * 3);
    return a;
  endfunction

  function automatic logic [127:0] mk_data(input int s);
    logic [127:0] d;
    for (int j = 0; j < 8; j++) d[j*16 +: 16] = 16'(s);
    return d;
  endfunction

  // Scoreboard: retire checks first, then record the request accepted this cycle.
  always @(negedge clk) begin
    int   occ;
    exp_t e;
    if (!reset) begin
      exp_q.delete();
    end else begin
      occ = exp_q.size();
      if (bus.deq_valid && bus.deq_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL deq_unexpected: got a dequeue expected none");
        end else begin
          e = exp_q.pop_front();
          n_deq++;
          chk("deq_is_store", bus.deq_is_store, e.st);
          chk("deq_warp", bus.deq_warp, e.warp);
          chk("deq_dest", bus.deq_dest, e.dest);
          chk("deq_mask", bus.deq_mask, e.mask);
          chk("deq_addr", bus.deq_addr, e.addr);
          chk("deq_data", bus.deq_data, e.data);
        end
      end
      if (bus.enq_valid) begin
        chk("enq_ready", bus.enq_ready, occ < DEPTH);
        if (occ < DEPTH) begin
          e.st   = bus.enq_is_store;
          e.warp = bus.enq_warp;
          e.dest = bus.enq_dest;
          e.mask = bus.enq_mask;
          e.addr = bus.enq_addr;
          e.data = bus.enq_data;
          exp_q.push_back(e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_enq(input logic v, input logic st, input int w, input int d,
                         input logic [7:0] m, input int seed);
    bus.enq_valid    = v;
    bus.enq_is_store = st;
    bus.enq_warp     = 2'(w);
    bus.enq_dest     = 4'(d);
    bus.enq_mask     = m;
    bus.enq_addr     = mk_addr(seed);
    bus.enq_data     = mk_data(seed);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, cyc, n0;
    logic acc;
    set_enq(1'b0, 1'b0, 0, 0, 8'h00, 0);
    bus.deq_ready = 1'b0;
    reset = 1'b0;
    step();
    step();
    chk("rst_empty", bus.empty, 1'b1);
    chk("rst_full", bus.full, 1'b0);
    chk("rst_enq_ready", bus.enq_ready, 1'b1);
    chk("rst_deq_valid", bus.deq_valid, 1'b0);
    chk("rst_count", bus.count, 0);
    chk("rst_deq_data", bus.deq_data, 0);
    reset = 1'b1;
    step();

    // Single load: visible exactly five edges after the enqueue edge.
    bus.deq_ready = 1'b1;
    set_enq(1'b1, 1'b0, 2, 7, 8'hFF, 1);
    step();
    bus.enq_valid = 1'b0;
    chk("single_count1", bus.count, 1);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("single_lat_wait", bus.deq_valid, 1'b0);
    end
    step();
    chk("single_lat_hit", bus.deq_valid, 1'b1);
    step();
    chk("single_count0", bus.count, 0);
    chk("single_empty", bus.empty, 1'b1);

    // Fill to DEPTH, then one rejected extra request.
    bus.deq_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      set_enq(1'b1, i[0], i, i, 8'(i * 37 + 1), i + 10);
      step();
    end
    chk("fill_full", bus.full, 1'b1);
    chk("fill_enq_ready", bus.enq_ready, 1'b0);
    chk("fill_count", bus.count, DEPTH);
    set_enq(1'b1, 1'b1, 3, 15, 8'hAA, 999);
    step();
    chk("fill_reject_count", bus.count, DEPTH);

    // Full with simultaneous dequeue: enqueue still refused.
    bus.deq_ready = 1'b1;
    step();
    chk("full_simul_count", bus.count, DEPTH - 1);
    bus.enq_valid = 1'b0;
    bus.deq_ready = 1'b0;

    // Backpressure: head stays presented and stable.
    for (int k = 0; k < 10; k++) begin
      step();
      chk("bp_deq_valid", bus.deq_valid, 1'b1);
      if (exp_q.size() > 0) begin
        chk("bp_deq_data", bus.deq_data, exp_q[0].data);
        chk("bp_deq_dest", bus.deq_dest, exp_q[0].dest);
      end
    end
    bus.deq_ready = 1'b1;
    for (int k = 1; k <= DEPTH - 1; k++) begin
      step();
      chk("drain_rate_count", bus.count, DEPTH - 1 - k);
    end
    chk("drain_empty", bus.empty, 1'b1);

    // Simultaneous enqueue/dequeue at count 4.
    bus.deq_ready = 1'b0;
    for (int i = 40; i < 44; i++) begin
      set_enq(1'b1, 1'b0, i, i, 8'h0F, i);
      step();
    end
    bus.enq_valid = 1'b0;
    repeat (6) step();
    set_enq(1'b1, 1'b1, 1, 3, 8'hF0, 44);
    bus.deq_ready = 1'b1;
    step();
    chk("simul4_count", bus.count, 4);
    bus.enq_valid = 1'b0;
    cyc = 0;
    while (!bus.empty && cyc < 40) begin
      step();
      cyc++;
    end
    chk("simul4_drained", bus.empty, 1'b1);

    // Wrap-around stream of stores with random backpressure.
    n0 = n_deq;
    idx = 0;
    cyc = 0;
    while (idx < 100 && cyc < 3000) begin
      set_enq(1'b1, 1'b1, idx, idx, 8'(idx * 29 + 3), idx);
      bus.deq_ready = 1'($urandom_range(0, 1));
      acc = bus.enq_ready;
      step();
      if (acc) idx++;
      cyc++;
    end
    chk("wrap_issued", idx, 100);
    bus.enq_valid = 1'b0;
    bus.deq_ready = 1'b1;
    cyc = 0;
    while (!bus.empty && cyc < 200) begin
      step();
      cyc++;
    end
    chk("wrap_empty", bus.empty, 1'b1);
    chk("wrap_deq_total", n_deq - n0, 100);

    // Reset with ten entries queued, then a fresh request.
    bus.deq_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      set_enq(1'b1, 1'b0, i, i, 8'h55, 200 + i);
      step();
    end
    bus.enq_valid = 1'b0;
    repeat (6) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("mid_rst_empty", bus.empty, 1'b1);
    chk("mid_rst_count", bus.count, 0);
    chk("mid_rst_deq_valid", bus.deq_valid, 1'b0);
    bus.deq_ready = 1'b1;
    set_enq(1'b1, 1'b1, 3, 9, 8'h81, 77);
    step();
    bus.enq_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("post_rst_lat_wait", bus.deq_valid, 1'b0);
    end
    step();
    chk("post_rst_lat_hit", bus.deq_valid, 1'b1);
    step();
    chk("post_rst_empty", bus.empty, 1'b1);

    chk("sb_leftover", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsq_param.md
Name: lsq_param

Overview:
- Parametrised load/store queue for the compute unit. Successor to the fixed 8-lane, 32-entry LSQ.
- Accepts per-warp memory requests from the controller: load or store, per-lane addresses, store data and a lane mask.
- Holds each request for a modelled memory latency, then retires requests strictly in order through a valid/ready dequeue port toward the register-file writeback path.
- Adds what the previous block lacked: store data, lane mask, enqueue/dequeue handshakes, occupancy output and configurable latency.

Parameters:
- LANES, 8, threads per warp; one address/data slot per lane.
- ADDR_WIDTH, 8, per-lane address width.
- DATA_WIDTH, 16, per-lane store data width.
- DEPTH, 32, queue entries; power of two, at least 2.
- MEM_LATENCY, 5, cycles an entry waits before it may retire; range 0..255.
- WARP_BITS, 2, warp id width.
- REG_BITS, 4, destination register index width.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset; reset==0 at a clk edge resets the block.
- enq_valid  in  1  request present.
- enq_ready  out  1  queue can accept; equals !full.
- enq_is_store  in  1  0=load, 1=store.
- enq_warp  in  WARP_BITS  issuing warp.
- enq_dest  in  REG_BITS  load destination register.
- enq_mask  in  LANES  active lanes.
- enq_addr  in  LANES*ADDR_WIDTH  lane i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- enq_data  in  LANES*DATA_WIDTH  store data, same packing.
- deq_valid  out  1  head entry complete.
- deq_ready  in  1  consumer accepts head.
- deq_is_store, deq_warp, deq_dest, deq_mask, deq_addr, deq_data  out  same widths as enq_*  fields of the head entry.
- count  out  $clog2(DEPTH)+1  occupied entries.
- full  out  1  count==DEPTH.
- empty  out  1  count==0.

Behaviour:
- Reset (reset==0 at an edge): all entries invalid, pointers=0, count=0. Outputs: empty=1, full=0, enq_ready=1, deq_valid=0, all deq_* fields 0.
- Reset mid-operation discards all queued entries; no retire occurs in the reset cycle.
- Enqueue fires on an edge where enq_valid && enq_ready. The entry at wr_ptr is written with all fields, valid=1 and timer=MEM_LATENCY; wr_ptr increments modulo DEPTH.
- An enqueue while full is blocked (enq_ready=0). There is no bypass: a full queue with a same-cycle dequeue still rejects the enqueue.
- Timers: every valid entry with timer>0 decrements by 1 each edge, independent of head position. Entries behind a stalled head keep counting.
- deq_valid = head valid && head timer==0, driven combinationally from the head entry. deq_* fields are 0 when the head is invalid.
- Latency: an entry enqueued at edge E asserts deq_valid after edge E+MEM_LATENCY. With MEM_LATENCY=0, deq_valid is high in the cycle right after enqueue.
- Dequeue fires on deq_valid && deq_ready. The head is cleared (valid=0), rd_ptr increments modulo DEPTH, and the next head may present in the following cycle, giving a throughput of 1/cycle.
- deq_valid and all deq_* fields stay stable while deq_ready=0.
- Simultaneous enqueue and dequeue: count unchanged; both pointers advance.
- count is updated with +1, -1 or 0 in the same edge as the pointers. full and empty are derived from count, so there is no pointer-equality ambiguity.
- Pointers wrap naturally at DEPTH (power of two).
- Masked-off lanes are stored unchanged; the mask is passed through to the consumer.

Optional Feature:
- Macro LSQ_PERF_CNT_EN.
- Defined: adds three 32-bit saturating output counters, each cleared by reset:
  - perf_loads: dequeued loads.
  - perf_stores: dequeued stores.
  - perf_stall: cycles with enq_valid && !enq_ready.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package lsq_pkg holds:
  - typedef lsq_op_e {LSQ_LOAD=1'b0, LSQ_STORE=1'b1}.
  - Parametrised entry struct: valid, timer, op, warp, dest, mask, addr, data.
  - Default width constants shared with the controller.
- One sub-module, lsq_entry_timer: the per-entry countdown, with load, decrement-while-nonzero and done output. It is instantiated DEPTH times.

Test Plan:
- Single load, MEM_LATENCY=5, deq_ready=1: enqueue at edge 0 with warp=2, dest=7, mask=8'hFF -> deq_valid rises after edge 5 with matching fields; count goes 1 then 0 after dequeue.
- Fill: 32 back-to-back enqueues with deq_ready=0 -> after the 32nd, full=1, enq_ready=0, count=32; the 33rd request is not accepted and the queue is unchanged.
- Backpressure: head complete and deq_ready held 0 for 10 cycles -> deq_* fields stable; entries behind it reach timer=0 and then retire 1/cycle once deq_ready=1.
- Simultaneous enqueue/dequeue at count=32 -> enqueue rejected, count=31. At count=4 with both firing -> count stays 4.
- Wrap-around: 100 streamed store requests with random deq_ready, data=index -> in-order output, data matches index, no loss or duplication.
- Reset mid-operation: reset=0 for one edge with 10 entries queued -> empty=1, count=0, deq_valid=0 next cycle; a fresh enqueue then retires after MEM_LATENCY.
